// File: rtl/clock_period_meter.sv
// Measures the half-period of a slow, possibly asynchronous square wave on CLOCK and reports lock.
// Optional macro PERIOD_METER_TOL_EN: accept +/-1 cycle of jitter when tracking the reference interval.
module clock_period_meter #(
    parameter int CNT_W          = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic             CLOCK,
    input  logic             RESETN,
    input  logic             SIG_IN,
    output logic             EDGE_PULSE,
    output logic [CNT_W-1:0] MEASURE_N,
    output logic             VALID,
    output logic             LOCKED,
    output logic             TIMEOUT
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1) + 1;
    localparam logic [MATCH_W-1:0] LOCK_M    = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic               LOCK_ON_FIRST = (LOCK_COUNT == 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("clock_period_meter: SYNC_STAGES must be at least 2");
        end
        if (LOCK_COUNT < 1) begin : g_bad_lock
            $error("clock_period_meter: LOCK_COUNT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       ref_q, ref_d;
    logic [MATCH_W-1:0]     match_q, match_d;
    logic [CNT_W-1:0]       meas_q, meas_d;
    logic                   valid_q, valid_d;
    logic                   locked_q, locked_d;
    logic                   edge_det;
    logic                   is_match;
    logic                   timeout_now;

`ifdef PERIOD_METER_TOL_EN
    localparam logic signed [CNT_W:0] ONE_S = (CNT_W+1)'(1);
    logic signed [CNT_W:0] diff;

    always_comb begin
        diff     = $signed({1'b0, cnt_q}) - $signed({1'b0, ref_q});
        is_match = (diff <= ONE_S) && (diff >= -ONE_S);
    end
`else
    always_comb begin
        is_match = (cnt_q == ref_q);
    end
`endif

    always_comb begin
        edge_det    = sync_q[SYNC_STAGES-1] ^ prev_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], SIG_IN};
        prev_d      = sync_q[SYNC_STAGES-1];
        state_d     = state_q;
        ref_d       = ref_q;
        match_d     = match_q;
        meas_d      = meas_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_now = 1'b0;
        // Saturate instead of wrapping so a stalled input never aliases to a short period.
        if (edge_det) begin
            cnt_d = '0;
        end else if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (edge_det) begin
                    state_d = ARMED;
                end
            end
            default: begin
                if (edge_det) begin
                    meas_d  = cnt_q;
                    valid_d = 1'b1;
                    state_d = TRACK;
                    if (state_q == TRACK && is_match) begin
                        // Reference is left alone on a match so tolerance cannot walk it away.
                        match_d  = (match_q >= LOCK_M) ? LOCK_M : match_q + MATCH_ONE;
                        locked_d = (match_q + MATCH_ONE) >= LOCK_M;
                    end else begin
                        ref_d    = cnt_q;
                        match_d  = MATCH_ONE;
                        locked_d = LOCK_ON_FIRST;
                    end
                end else if (cnt_q == TO_LAST) begin
                    timeout_now = 1'b1;
                    locked_d    = 1'b0;
                    match_d     = '0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            ref_q    <= '0;
            match_q  <= '0;
            meas_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            ref_q    <= ref_d;
            match_q  <= match_d;
            meas_q   <= meas_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
        end
    end

    assign EDGE_PULSE = edge_det;
    assign MEASURE_N  = meas_q;
    assign VALID      = valid_q;
    assign LOCKED     = locked_q;
    assign TIMEOUT    = timeout_now;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: divider-driven input, lock tracking, timeout, async reset, tolerance.
module tb_clock_period_meter;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic             sig_in;
    logic             edge_pulse;
    logic [CNT_W-1:0] measure_n;
    logic             valid;
    logic             locked;
    logic             timeout;

    clock_period_meter #(
        .CNT_W          (CNT_W),
        .SYNC_STAGES    (2),
        .LOCK_COUNT     (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .CLOCK      (clk),
        .RESETN     (rst_n),
        .SIG_IN     (sig_in),
        .EDGE_PULSE (edge_pulse),
        .MEASURE_N  (measure_n),
        .VALID      (valid),
        .LOCKED     (locked),
        .TIMEOUT    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: records every VALID update plus edge/timeout activity, sampled on the falling edge.
    int               cyc = 0;
    int               edge_cnt = 0;
    int               to_cnt = 0;
    int               last_edge_cyc = 0;
    int               to_cyc = 0;
    logic [CNT_W-1:0] mq[$];
    bit               lq[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (valid) begin
                mq.push_back(measure_n);
                lq.push_back(locked);
            end
            if (edge_pulse) begin
                edge_cnt      = edge_cnt + 1;
                last_edge_cyc = cyc;
            end
            if (timeout) begin
                to_cnt = to_cnt + 1;
                to_cyc = cyc;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        sig_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_edge", edge_pulse, 0);
        chk("reset_meas", measure_n, 0);
        chk("reset_valid", valid, 0);
        chk("reset_locked", locked, 0);
        chk("reset_timeout", timeout, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Divider with setting n toggles every n+1 clocks.
    task automatic toggles(input int n, input int count);
        repeat (count) begin
            repeat (n + 1) @(negedge clk);
            sig_in = ~sig_in;
        end
    endtask

    task automatic flush();
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        int n;
        int toggles;
        int exp_valids;
        int exp_meas;
        int lock_idx;   // first VALID (1-based) carrying LOCKED=1; 0 = never
    } vec_t;

    vec_t vecs[5];
    int   vb, eb, tb0, nv;

    initial begin
        rst_n  = 1'b1;
        sig_in = 1'b0;

        vecs[0] = '{n: 5, toggles: 8, exp_valids: 7, exp_meas: 5, lock_idx: 4};
        vecs[1] = '{n: 0, toggles: 8, exp_valids: 7, exp_meas: 0, lock_idx: 4};
        vecs[2] = '{n: 1, toggles: 5, exp_valids: 4, exp_meas: 1, lock_idx: 4};
        vecs[3] = '{n: 2, toggles: 4, exp_valids: 3, exp_meas: 2, lock_idx: 0};
        vecs[4] = '{n: 12, toggles: 7, exp_valids: 6, exp_meas: 12, lock_idx: 4};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            vb  = mq.size();
            eb  = edge_cnt;
            tb0 = to_cnt;
            toggles(vecs[i].n, vecs[i].toggles);
            flush();
            nv = mq.size() - vb;
            chk($sformatf("v%0d_valids", i), nv, vecs[i].exp_valids);
            chk($sformatf("v%0d_edges", i), edge_cnt - eb, vecs[i].toggles);
            chk($sformatf("v%0d_timeouts", i), to_cnt - tb0, 0);
            for (int k = 0; k < nv; k++) begin
                chk($sformatf("v%0d_meas%0d", i, k), mq[vb+k], vecs[i].exp_meas);
                chk($sformatf("v%0d_lock%0d", i, k), lq[vb+k],
                    (vecs[i].lock_idx != 0 && k + 1 >= vecs[i].lock_idx) ? 1 : 0);
            end
        end

        // Lock at n=9, then switch to n=3 without a gap.
        do_reset();
        vb = mq.size();
        toggles(9, 6);
        toggles(3, 6);
        flush();
        chk("sw_valids", mq.size() - vb, 11);
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("sw_meas%0d", k), mq[vb+k], (k < 5) ? 9 : 3);
            chk($sformatf("sw_lock%0d", k), lq[vb+k],
                (k < 5) ? ((k >= 3) ? 1 : 0) : ((k - 5 >= 3) ? 1 : 0));
        end

        // Loss of signal after lock.
        do_reset();
        vb  = mq.size();
        tb0 = to_cnt;
        toggles(5, 6);
        flush();
        chk("to_locked_before", locked, 1);
        repeat (120) @(negedge clk);
        chk("to_pulses", to_cnt - tb0, 1);
        chk("to_delay", to_cyc - last_edge_cyc, 50);
        chk("to_locked_after", locked, 0);
        chk("to_meas_kept", measure_n, 5);
        vb = mq.size();
        eb = edge_cnt;
        toggles(5, 2);
        flush();
        chk("to_rearm_edges", edge_cnt - eb, 2);
        chk("to_rearm_valids", mq.size() - vb, 1);
        if (mq.size() > vb) chk("to_rearm_meas", mq[vb], 5);

        // Asynchronous reset in the middle of an interval.
        do_reset();
        toggles(5, 4);
        flush();
        chk("ar_meas_before", measure_n, 5);
        @(negedge clk);
        #3;
        rst_n  = 1'b0;
        sig_in = 1'b0;
        #1;
        chk("ar_edge", edge_pulse, 0);
        chk("ar_meas", measure_n, 0);
        chk("ar_valid", valid, 0);
        chk("ar_locked", locked, 0);
        chk("ar_timeout", timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        vb = mq.size();
        eb = edge_cnt;
        toggles(5, 2);
        flush();
        chk("ar_edges", edge_cnt - eb, 2);
        chk("ar_valids", mq.size() - vb, 1);
        if (mq.size() > vb) chk("ar_first_meas", mq[vb], 5);

        // Intervals alternating 7,8,...: locks only with tolerance enabled.
        do_reset();
        vb = mq.size();
        toggles(3, 1);
        for (int k = 0; k < 7; k++) toggles((k % 2 == 0) ? 7 : 8, 1);
        flush();
        chk("tol_valids", mq.size() - vb, 7);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("tol_meas%0d", k), mq[vb+k], (k % 2 == 0) ? 7 : 8);
`ifdef PERIOD_METER_TOL_EN
            chk($sformatf("tol_lock%0d", k), lq[vb+k], (k >= 3) ? 1 : 0);
`else
            chk($sformatf("tol_lock%0d", k), lq[vb+k], 0);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
